// File: rtl/sdram_iface_pkg.sv
// Shared definitions for the SDRAM framebuffer interface: the read-modify-write
// state encoding and the pixel-to-byte-address mapping also used by the display path.
package sdram_iface_pkg;

    localparam int BYTES_PER_PIXEL = 4;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        COMPUTE,
        WR_REQ,
        ADVANCE,
        DONE
    } rmw_state_e;

    // Byte address of pixel (x, y) in a linear framebuffer with the given row stride.
    function automatic logic [31:0] pixel_addr(input logic [31:0] base,
                                               input logic [31:0] x,
                                               input logic [31:0] y,
                                               input logic [31:0] stride);
        return base + ((y * stride + x) * 32'(BYTES_PER_PIXEL));
    endfunction

endpackage

// File: rtl/region_scanner.sv
// Raster-order walker over a rectangle. `last` says a step from the current pixel
// leaves the region; `clipped` is the screen-clip flag of the pixel that load/step
// selects this cycle, so the controller can branch in the same cycle it moves.
module region_scanner
    import sdram_iface_pkg::*;
#(
    parameter int COORD_W  = 16,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic [COORD_W-1:0] x_start,
    input  logic [COORD_W-1:0] y_start,
    input  logic [COORD_W-1:0] x_length,
    input  logic [COORD_W-1:0] y_length,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               last,
    output logic               clipped
);

    localparam logic [COORD_W-1:0] CLIP_X = COORD_W'(SCREEN_W);
    localparam logic [COORD_W-1:0] CLIP_Y = COORD_W'(SCREEN_H);
    localparam logic [COORD_W:0]   ONE    = {{COORD_W{1'b0}}, 1'b1};

    logic [COORD_W-1:0] x_org;
    // End bounds carry one extra bit so a region reaching 2^COORD_W stops instead of wrapping.
    logic [COORD_W:0]   x_end;
    logic [COORD_W:0]   y_end;
    logic [COORD_W:0]   x_inc;
    logic [COORD_W:0]   y_inc;
    logic               row_end;
    logic [COORD_W-1:0] x_nxt;
    logic [COORD_W-1:0] y_nxt;

    // Next-position selection, end-of-row/end-of-region detection and clip flag.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        x_nxt   = x;
        y_nxt   = y;
        x_inc   = {1'b0, x} + ONE;
        y_inc   = {1'b0, y} + ONE;
        row_end = x_inc[COORD_W] || (x_inc >= x_end);
        last    = row_end && (y_inc[COORD_W] || (y_inc >= y_end));
        if (load) begin
            x_nxt = x_start;
            y_nxt = y_start;
        end else if (step) begin
            if (row_end) begin
                x_nxt = x_org;
                y_nxt = y_inc[COORD_W-1:0];
            end else begin
                x_nxt = x_inc[COORD_W-1:0];
            end
        end
        clipped = (x_nxt >= CLIP_X) || (y_nxt >= CLIP_Y);
    end

    // Position counters and the region bounds captured at load.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x     <= '0;
            y     <= '0;
            x_org <= '0;
            x_end <= '0;
            y_end <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            x <= x_nxt;
            y <= y_nxt;
            if (load) begin
                x_org <= x_start;
                x_end <= {1'b0, x_start} + {1'b0, x_length};
                y_end <= {1'b0, y_start} + {1'b0, y_length};
            end
        end
    end

endmodule

// File: rtl/sdram_region_rmw.sv
// Region read-modify-write responder: walks a rectangle, reads each on-screen pixel
// from the SDRAM framebuffer, hands it to the client, and writes back the client's colour.
module sdram_region_rmw
    import sdram_iface_pkg::*;
#(
    parameter int          COORD_W     = 16,
    parameter int          COLOR_W     = 32,
    parameter int          ADDR_W      = 32,
    parameter logic [31:0] FB_BASE     = 32'h0000_0000,
    parameter int          SCREEN_W    = 640,
    parameter int          SCREEN_H    = 480,
    parameter int          COMPUTE_LAT = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [COORD_W-1:0] x_start,
    input  logic [COORD_W-1:0] y_start,
    input  logic [COORD_W-1:0] x_length,
    input  logic [COORD_W-1:0] y_length,
    output logic [COORD_W-1:0] current_x,
    output logic [COORD_W-1:0] current_y,
    output logic [COLOR_W-1:0] old_color,
    input  logic [COLOR_W-1:0] new_color,
    output logic               done,
    output logic               busy,
    output logic [ADDR_W-1:0]  avm_address,
    output logic               avm_read,
    output logic               avm_write,
    output logic [31:0]        avm_writedata,
    output logic [3:0]         avm_byteenable,
    input  logic [31:0]        avm_readdata,
    input  logic               avm_readdatavalid,
    input  logic               avm_waitrequest
);

    localparam int CNT_W = (COMPUTE_LAT > 1) ? $clog2(COMPUTE_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COMPUTE_LAT - 1);

    rmw_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             load;
    logic             step;
    logic             last;
    logic             clipped;
    logic [31:0]      pix_addr;
    logic             access;

    assign load = (state == IDLE) && start;
    assign step = (state == ADVANCE);

    region_scanner #(
        .COORD_W  (COORD_W),
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_scanner (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .step     (step),
        .x_start  (x_start),
        .y_start  (y_start),
        .x_length (x_length),
        .y_length (y_length),
        .x        (current_x),
        .y        (current_y),
        .last     (last),
        .clipped  (clipped)
    );

    // Address follows the registered pixel position; it is driven only while an access is active.
    assign access         = avm_read || avm_write;
    assign pix_addr       = pixel_addr(FB_BASE, 32'(current_x), 32'(current_y), 32'(SCREEN_W));
    assign avm_address    = access ? ADDR_W'(pix_addr) : '0;
    assign avm_byteenable = access ? 4'hF : 4'h0;

    // Per-pixel read-modify-write sequencer with registered bus and handshake outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_writedata <= '0;
            old_color     <= '0;
            done          <= 1'b0;
            busy          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (x_length == '0 || y_length == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            busy <= 1'b1;
                            if (clipped) begin
                                state <= ADVANCE;
                            end else begin
                                state    <= RD_REQ;
                                avm_read <= 1'b1;
                            end
                        end
                    end
                end
                RD_REQ: begin
                    if (!avm_waitrequest) begin
                        avm_read <= 1'b0;
                        state    <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (avm_readdatavalid) begin
                        old_color <= COLOR_W'(avm_readdata);
                        cnt       <= '0;
                        state     <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    if (cnt == CNT_LAST) begin
                        avm_writedata <= 32'(new_color);
                        avm_write     <= 1'b1;
                        state         <= WR_REQ;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WR_REQ: begin
                    if (!avm_waitrequest) begin
                        avm_write <= 1'b0;
                        state     <= ADVANCE;
                    end
                end
                ADVANCE: begin
                    if (last) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (!clipped) begin
                        state    <= RD_REQ;
                        avm_read <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_region_rmw.sv
// Directed bench for sdram_region_rmw: an Avalon-MM memory model (value = address
// unless written) with optional random waitrequest and read latency, a client that
// returns old_color + 1, and one task per scenario with hand-computed expectations.
module tb_sdram_region_rmw;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } op_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] x_start = '0;
    logic [15:0] y_start = '0;
    logic [15:0] x_length = '0;
    logic [15:0] y_length = '0;
    logic [15:0] current_x;
    logic [15:0] current_y;
    logic [31:0] old_color;
    logic [31:0] new_color = '0;
    logic        done;
    logic        busy;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata = '0;
    logic        avm_readdatavalid = 1'b0;
    logic        avm_waitrequest = 1'b0;

    int vectors = 0;
    int fails   = 0;

    // Memory model and logs
    logic [31:0] mem [logic [31:0]];
    op_t         ops [$];
    op_t         exp_ops [$];
    int          done_cnt = 0;
    int          bus_errs = 0;
    bit          random_wait = 1'b0;
    int          max_delay = 0;
    bit          rd_busy = 1'b0;
    int          rd_cd = 0;
    logic [31:0] rd_data = '0;
    bit          hold_rd = 1'b0;
    bit          hold_wr = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_data = '0;

    sdram_region_rmw dut (
        .clock             (clock),
        .reset             (reset),
        .start             (start),
        .x_start           (x_start),
        .y_start           (y_start),
        .x_length          (x_length),
        .y_length          (y_length),
        .current_x         (current_x),
        .current_y         (current_y),
        .old_color         (old_color),
        .new_color         (new_color),
        .done              (done),
        .busy              (busy),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_byteenable    (avm_byteenable),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .avm_waitrequest   (avm_waitrequest)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : a;
    endfunction

    // Slave + client model: drives responses just after posedge, samples requests at negedge.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (reset) begin
                rd_busy           = 1'b0;
                avm_readdatavalid = 1'b0;
                avm_waitrequest   = 1'b0;
            end else begin
                avm_readdatavalid = 1'b0;
                if (rd_busy) begin
                    if (rd_cd == 0) begin
                        avm_readdatavalid = 1'b1;
                        avm_readdata      = rd_data;
                        rd_busy           = 1'b0;
                    end else begin
                        rd_cd--;
                    end
                end
                avm_waitrequest = random_wait ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            new_color = old_color + 32'd1;
            @(negedge clock);
            if (!reset) begin
                if (done) done_cnt++;
                if (avm_read && avm_write) bus_errs++;
                if ((avm_read || avm_write) && avm_byteenable != 4'hF) bus_errs++;
                if (hold_rd && !(avm_read && avm_address == prev_addr)) bus_errs++;
                if (hold_wr && !(avm_write && avm_address == prev_addr && avm_writedata == prev_data)) bus_errs++;
                if (avm_read && !avm_waitrequest) begin
                    if (rd_busy) bus_errs++;
                    rd_data = mem_rd(avm_address);
                    rd_busy = 1'b1;
                    rd_cd   = $urandom_range(0, max_delay);
                    ops.push_back('{wr: 1'b0, addr: avm_address, data: rd_data});
                end
                if (avm_write && !avm_waitrequest) begin
                    mem[avm_address] = avm_writedata;
                    ops.push_back('{wr: 1'b1, addr: avm_address, data: avm_writedata});
                end
                hold_rd   = avm_read && avm_waitrequest;
                hold_wr   = avm_write && avm_waitrequest;
                prev_addr = avm_address;
                prev_data = avm_writedata;
            end else begin
                hold_rd = 1'b0;
                hold_wr = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Expected access sequence: read (value = address) then write of value + 1, raster order.
    task automatic build_expected(input int xs, input int ys, input int xl, input int yl);
        logic [31:0] a;
        exp_ops.delete();
        for (int yy = ys; yy < ys + yl; yy++) begin
            for (int xx = xs; xx < xs + xl; xx++) begin
                if (xx < 640 && yy < 480) begin
                    a = 32'(4 * (yy * 640 + xx));
                    exp_ops.push_back('{wr: 1'b0, addr: a, data: a});
                    exp_ops.push_back('{wr: 1'b1, addr: a, data: a + 32'd1});
                end
            end
        end
    endtask

    task automatic clear_logs();
        @(negedge clock);
        #2;
        ops.delete();
        mem.delete();
        done_cnt = 0;
        bus_errs = 0;
    endtask

    // Start is accepted at the posedge between the two negedges; returns in cycle T+1.
    task automatic pulse_start(input int xs, input int ys, input int xl, input int yl);
        @(negedge clock);
        x_start  = 16'(xs);
        y_start  = 16'(ys);
        x_length = 16'(xl);
        y_length = 16'(yl);
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // n = 1 means done observed in cycle T+1.
    task automatic wait_done(input int budget, output int n, output bit ok);
        n = 1;
        while (!done && n < budget) begin
            @(negedge clock);
            n++;
        end
        ok = done;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        vectors++;
        if ({avm_read, avm_write, done, busy} !== 4'b0) begin
            fails++;
            $display("FAIL reset ctrl: got rd/wr/done/busy=%b want 0000", {avm_read, avm_write, done, busy});
        end
        vectors++;
        if (avm_address !== 32'd0 || avm_byteenable !== 4'd0) begin
            fails++;
            $display("FAIL reset addr: got %h/%h want 0/0", avm_address, avm_byteenable);
        end
        vectors++;
        if (current_x !== 16'd0 || current_y !== 16'd0) begin
            fails++;
            $display("FAIL reset coord: got %0d,%0d want 0,0", current_x, current_y);
        end
        vectors++;
        if (old_color !== 32'd0 || avm_writedata !== 32'd0) begin
            fails++;
            $display("FAIL reset data: got %h/%h want 0/0", old_color, avm_writedata);
        end
        #2 reset = 1'b0;
        repeat (3) @(negedge clock);
        vectors++;
        if ({avm_read, avm_write, done, busy} !== 4'b0) begin
            fails++;
            $display("FAIL idle after reset: got rd/wr/done/busy=%b want 0000", {avm_read, avm_write, done, busy});
        end
    endtask

    task automatic test_basic();
        int n;
        bit ok;
        clear_logs();
        random_wait = 1'b0;
        max_delay   = 0;
        pulse_start(2, 3, 3, 2);
        vectors++;
        if (avm_read !== 1'b1 || avm_address !== 32'd7688) begin
            fails++;
            $display("FAIL basic first read: got rd=%b addr=%0d want rd=1 addr=7688", avm_read, avm_address);
        end
        vectors++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL basic busy T+1: got %b want 1", busy);
        end
        wait_done(200, n, ok);
        vectors++;
        if (!ok || n != 37) begin
            fails++;
            $display("FAIL basic done latency: got ok=%0d n=%0d want n=37", ok, n);
        end
        vectors++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL basic busy at done: got %b want 0", busy);
        end
        repeat (5) @(negedge clock);
        vectors++;
        if (done_cnt != 1) begin
            fails++;
            $display("FAIL basic done count: got %0d want 1", done_cnt);
        end
        build_expected(2, 3, 3, 2);
        vectors++;
        if (ops.size() != exp_ops.size()) begin
            fails++;
            $display("FAIL basic op count: got %0d want %0d", ops.size(), exp_ops.size());
        end
        foreach (exp_ops[i]) if (i < ops.size()) begin
            vectors++;
            if (ops[i] !== exp_ops[i]) begin
                fails++;
                $display("FAIL basic op %0d: got wr=%b a=%0d d=%0d want wr=%b a=%0d d=%0d", i,
                         ops[i].wr, ops[i].addr, ops[i].data, exp_ops[i].wr, exp_ops[i].addr, exp_ops[i].data);
            end
        end
    endtask

    task automatic test_empty();
        int n;
        bit ok;
        clear_logs();
        pulse_start(4, 4, 0, 5);
        wait_done(10, n, ok);
        vectors++;
        if (!ok || n != 1) begin
            fails++;
            $display("FAIL empty done latency: got ok=%0d n=%0d want n=1", ok, n);
        end
        vectors++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL empty busy: got %b want 0", busy);
        end
        repeat (5) @(negedge clock);
        vectors++;
        if (ops.size() != 0 || done_cnt != 1) begin
            fails++;
            $display("FAIL empty accesses/done: got ops=%0d done=%0d want 0/1", ops.size(), done_cnt);
        end
    endtask

    task automatic test_clip();
        int n;
        bit ok;
        clear_logs();
        pulse_start(638, 0, 4, 1);
        wait_done(100, n, ok);
        vectors++;
        if (!ok || n != 15) begin
            fails++;
            $display("FAIL clip done latency: got ok=%0d n=%0d want n=15", ok, n);
        end
        repeat (5) @(negedge clock);
        vectors++;
        if (done_cnt != 1) begin
            fails++;
            $display("FAIL clip done count: got %0d want 1", done_cnt);
        end
        build_expected(638, 0, 4, 1);
        vectors++;
        if (ops.size() != exp_ops.size()) begin
            fails++;
            $display("FAIL clip op count: got %0d want %0d", ops.size(), exp_ops.size());
        end
        foreach (exp_ops[i]) if (i < ops.size()) begin
            vectors++;
            if (ops[i] !== exp_ops[i]) begin
                fails++;
                $display("FAIL clip op %0d: got wr=%b a=%0d d=%0d want wr=%b a=%0d d=%0d", i,
                         ops[i].wr, ops[i].addr, ops[i].data, exp_ops[i].wr, exp_ops[i].addr, exp_ops[i].data);
            end
        end
    endtask

    task automatic test_random_wait();
        int n;
        bit ok;
        clear_logs();
        random_wait = 1'b1;
        max_delay   = 7;
        pulse_start(100, 50, 3, 2);
        wait_done(3000, n, ok);
        vectors++;
        if (!ok) begin
            fails++;
            $display("FAIL random done: got timeout after %0d cycles want done", n);
        end
        repeat (10) @(negedge clock);
        random_wait = 1'b0;
        max_delay   = 0;
        vectors++;
        if (bus_errs != 0 || done_cnt != 1) begin
            fails++;
            $display("FAIL random protocol: got errs=%0d done=%0d want 0/1", bus_errs, done_cnt);
        end
        build_expected(100, 50, 3, 2);
        vectors++;
        if (ops.size() != exp_ops.size()) begin
            fails++;
            $display("FAIL random op count: got %0d want %0d", ops.size(), exp_ops.size());
        end
        foreach (exp_ops[i]) if (i < ops.size()) begin
            vectors++;
            if (ops[i] !== exp_ops[i]) begin
                fails++;
                $display("FAIL random op %0d: got wr=%b a=%0d d=%0d want wr=%b a=%0d d=%0d", i,
                         ops[i].wr, ops[i].addr, ops[i].data, exp_ops[i].wr, exp_ops[i].addr, exp_ops[i].data);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int seen;
        int k;
        bit ok;
        clear_logs();
        pulse_start(2, 3, 3, 2);
        seen = 0;
        k = 0;
        while (seen < 2 && k < 200) begin
            if (avm_write) seen++;
            if (seen < 2) begin
                @(negedge clock);
                k++;
            end
        end
        vectors++;
        if (seen != 2) begin
            fails++;
            $display("FAIL rstmid reach 2nd write: got %0d writes want 2", seen);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({avm_read, avm_write, done, busy} !== 4'b0) begin
            fails++;
            $display("FAIL rstmid ctrl: got rd/wr/done/busy=%b want 0000", {avm_read, avm_write, done, busy});
        end
        vectors++;
        if (avm_address !== 32'd0 || current_x !== 16'd0 || current_y !== 16'd0) begin
            fails++;
            $display("FAIL rstmid position: got a=%0d x=%0d y=%0d want 0", avm_address, current_x, current_y);
        end
        vectors++;
        if (old_color !== 32'd0 || avm_writedata !== 32'd0) begin
            fails++;
            $display("FAIL rstmid data: got %h/%h want 0/0", old_color, avm_writedata);
        end
        @(negedge clock);
        #2 reset = 1'b0;
        clear_logs();
        pulse_start(2, 3, 3, 2);
        wait_done(200, n, ok);
        vectors++;
        if (!ok || n != 37) begin
            fails++;
            $display("FAIL rstmid rerun latency: got ok=%0d n=%0d want n=37", ok, n);
        end
        repeat (5) @(negedge clock);
        vectors++;
        if (done_cnt != 1) begin
            fails++;
            $display("FAIL rstmid done count: got %0d want 1", done_cnt);
        end
        build_expected(2, 3, 3, 2);
        vectors++;
        if (ops.size() != exp_ops.size()) begin
            fails++;
            $display("FAIL rstmid op count: got %0d want %0d", ops.size(), exp_ops.size());
        end
        foreach (exp_ops[i]) if (i < ops.size()) begin
            vectors++;
            if (ops[i] !== exp_ops[i]) begin
                fails++;
                $display("FAIL rstmid op %0d: got wr=%b a=%0d d=%0d want wr=%b a=%0d d=%0d", i,
                         ops[i].wr, ops[i].addr, ops[i].data, exp_ops[i].wr, exp_ops[i].addr, exp_ops[i].data);
            end
        end
    endtask

    task automatic test_mid_start();
        int n;
        bit ok;
        clear_logs();
        pulse_start(2, 3, 3, 2);
        repeat (10) @(negedge clock);
        x_start  = 16'd50;
        y_start  = 16'd60;
        x_length = 16'd7;
        y_length = 16'd7;
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done(300, n, ok);
        vectors++;
        if (!ok) begin
            fails++;
            $display("FAIL midstart done: got timeout after %0d cycles want done", n);
        end
        repeat (5) @(negedge clock);
        vectors++;
        if (done_cnt != 1) begin
            fails++;
            $display("FAIL midstart done count: got %0d want 1", done_cnt);
        end
        build_expected(2, 3, 3, 2);
        vectors++;
        if (ops.size() != exp_ops.size()) begin
            fails++;
            $display("FAIL midstart op count: got %0d want %0d", ops.size(), exp_ops.size());
        end
        foreach (exp_ops[i]) if (i < ops.size()) begin
            vectors++;
            if (ops[i] !== exp_ops[i]) begin
                fails++;
                $display("FAIL midstart op %0d: got wr=%b a=%0d d=%0d want wr=%b a=%0d d=%0d", i,
                         ops[i].wr, ops[i].addr, ops[i].data, exp_ops[i].wr, exp_ops[i].addr, exp_ops[i].data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty();
        test_clip();
        test_random_wait();
        test_reset_mid();
        test_mid_start();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
